// File: rtl/vt52_key_encoder.sv
// VT52 keyboard-to-host encoder.
// Buffers key events in a small FIFO and turns each one into the VT52 host byte
// stream (plain ASCII or ESC-prefixed cursor/function sequences). Also answers
// the host identify request with ESC / ID_CHAR. Output is an AXI-stream byte
// master feeding the UART transmitter.
// Optional build macro: VT52_KEY_CRLF_EN -- when defined, key 8'h0D emits CR LF.
`timescale 1ns/1ps

module vt52_key_encoder #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  ID_CHAR    = 8'h4B
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] key_code,
  input  logic       key_valid,
  input  logic       ident_req,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       key_overflow,
  output logic       busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  localparam logic [7:0] ESC   = 8'h1B;
  localparam logic [7:0] SLASH = 8'h2F;

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_SEND_CHAR   = 3'd1;
  localparam logic [2:0] S_SEND_ESC    = 3'd2;
  localparam logic [2:0] S_SEND_SUFFIX = 3'd3;
  localparam logic [2:0] S_ID_ESC      = 3'd4;
  localparam logic [2:0] S_ID_SLASH    = 3'd5;
  localparam logic [2:0] S_ID_CHAR     = 3'd6;
`ifdef VT52_KEY_CRLF_EN
  localparam logic [2:0] S_SEND_LF     = 3'd7;
`endif

  localparam logic [1:0] KIND_CHAR = 2'd0;
  localparam logic [1:0] KIND_ESC  = 2'd1;
  localparam logic [1:0] KIND_DROP = 2'd2;

  // Classify a popped key code: plain ASCII, ESC sequence, or silently dropped.
  function automatic logic [1:0] code_kind(input logic [7:0] c);
    if (!c[7])            code_kind = KIND_CHAR;
    else if (c <= 8'h86)  code_kind = KIND_ESC;
    else                  code_kind = KIND_DROP;
  endfunction

  // Second byte of an ESC sequence: cursor keys A-D, function keys P-R.
  function automatic logic [7:0] esc_suffix(input logic [7:0] c);
    case (c)
      8'h80:   esc_suffix = 8'h41;
      8'h81:   esc_suffix = 8'h42;
      8'h82:   esc_suffix = 8'h43;
      8'h83:   esc_suffix = 8'h44;
      8'h84:   esc_suffix = 8'h50;
      8'h85:   esc_suffix = 8'h51;
      8'h86:   esc_suffix = 8'h52;
      default: esc_suffix = 8'h00;
    endcase
  endfunction

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic [7:0]    head;

  logic [2:0]    state_q, state_d;
  logic [7:0]    tdata_q, tdata_d;
  logic          tvalid_q, tvalid_d;
  logic [7:0]    suffix_q, suffix_d;
  logic          pend_q, pend_d;
  logic          ovf_q, ovf_d;
  logic          id_enter;
  logic          hs;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_push  = key_valid && !fifo_full;
  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign hs         = tvalid_q && m_axis_tready;

  // Pointer, flag and overflow next-state; push and pop may happen together.
  always_comb begin
    wr_ptr_d = fifo_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = fifo_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    ovf_d    = ovf_q | (key_valid & fifo_full);
    // A new request wins over the clear so a request landing mid-identify re-arms.
    pend_d   = ident_req ? 1'b1 : (id_enter ? 1'b0 : pend_q);
  end

  // Output sequencer: IDLE loads the first byte of a sequence, every other state
  // advances to the next byte on the handshake edge so bytes follow without a gap.
  always_comb begin
    state_d  = state_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    suffix_d = suffix_q;
    fifo_pop = 1'b0;
    id_enter = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          state_d  = S_ID_ESC;
          tdata_d  = ESC;
          tvalid_d = 1'b1;
          id_enter = 1'b1;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          case (code_kind(head))
            KIND_CHAR: begin
              state_d  = S_SEND_CHAR;
              tdata_d  = head;
              tvalid_d = 1'b1;
            end
            KIND_ESC: begin
              state_d  = S_SEND_ESC;
              tdata_d  = ESC;
              tvalid_d = 1'b1;
              suffix_d = esc_suffix(head);
            end
            default: ;
          endcase
        end
      end
      S_SEND_CHAR: begin
        if (hs) begin
`ifdef VT52_KEY_CRLF_EN
          if (tdata_q == 8'h0D) begin
            state_d = S_SEND_LF;
            tdata_d = 8'h0A;
          end else begin
            state_d  = S_IDLE;
            tvalid_d = 1'b0;
          end
`else
          state_d  = S_IDLE;
          tvalid_d = 1'b0;
`endif
        end
      end
      S_SEND_ESC: begin
        if (hs) begin
          state_d = S_SEND_SUFFIX;
          tdata_d = suffix_q;
        end
      end
      S_ID_ESC: begin
        if (hs) begin
          state_d = S_ID_SLASH;
          tdata_d = SLASH;
        end
      end
      S_ID_SLASH: begin
        if (hs) begin
          state_d = S_ID_CHAR;
          tdata_d = ID_CHAR;
        end
      end
`ifdef VT52_KEY_CRLF_EN
      S_SEND_LF,
`endif
      S_SEND_SUFFIX,
      S_ID_CHAR: begin
        if (hs) begin
          state_d  = S_IDLE;
          tvalid_d = 1'b0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        tvalid_d = 1'b0;
      end
    endcase
  end

  // Control and output registers; reset abandons any sequence in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= S_IDLE;
      tdata_q  <= 8'h00;
      tvalid_q <= 1'b0;
      pend_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      state_q  <= state_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
    end
  end

  // Key storage and pending suffix byte; contents are don't-care until valid.
  always_ff @(posedge clk) begin
    if (fifo_push) mem_q[wr_ptr_q[AW-1:0]] <= key_code;
    suffix_q <= suffix_d;
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign key_overflow  = ovf_q;
  assign busy          = !fifo_empty || (state_q != S_IDLE) || pend_q;

endmodule

// File: tb/tb_vt52_key_encoder.sv
// Testbench for vt52_key_encoder: directed steps with a byte scoreboard.
// Honours VT52_KEY_CRLF_EN when the bench is built with the same macro.
`timescale 1ns/1ps

module tb_vt52_key_encoder;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic       key_valid = 1'b0;
  logic       ident_req = 1'b0;
  logic       m_axis_tready = 1'b0;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       key_overflow;
  logic       busy;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q [$];
  logic       stall_q = 1'b0;
  logic [7:0] stall_data = 8'h00;

  vt52_key_encoder #(.FIFO_DEPTH(4), .ID_CHAR(8'h4B)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .key_code      (key_code),
    .key_valid     (key_valid),
    .ident_req     (ident_req),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .key_overflow  (key_overflow),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Scoreboard and hold checker, sampled on the falling edge: a byte seen with
  // tvalid&tready here is the one accepted on the next rising edge.
  always @(negedge clk) begin
    if (rstn) begin
      if (stall_q) begin
        check1("hold_valid", m_axis_tvalid, 1'b1);
        check("hold_data", m_axis_tdata, stall_data);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        vectors++;
        assert (exp_q.size() != 0) else begin
          miscompares++;
          $error("FAIL extra_byte observed=%h expected=none", m_axis_tdata);
        end
        if (exp_q.size() != 0) check("stream_byte", m_axis_tdata, exp_q.pop_front());
      end
      stall_q    = m_axis_tvalid && !m_axis_tready;
      stall_data = m_axis_tdata;
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [7:0] c);
    key_code  = c;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) step();
    vectors++;
    assert (exp_q.size() == 0) else begin
      miscompares++;
      $error("FAIL %s_timeout observed=%0d expected=0 bytes outstanding", tag, exp_q.size());
    end
    exp_q.delete();
    repeat (4) step();
    check1({tag, "_idle_tvalid"}, m_axis_tvalid, 1'b0);
    check1({tag, "_idle_busy"}, busy, 1'b0);
  endtask

  // Hold the second byte of a two-byte sequence, then reset underneath it.
  task automatic reset_mid(input string tag, input logic [7:0] code,
                           input logic [7:0] b0, input logic [7:0] b1);
    m_axis_tready = 1'b0;
    exp_q.push_back(b0);
    exp_q.push_back(b1);
    key(code);
    step();
    check({tag, "_first"}, m_axis_tdata, b0);
    m_axis_tready = 1'b1;
    step();
    m_axis_tready = 1'b0;
    check({tag, "_second"}, m_axis_tdata, b1);
    check1({tag, "_second_valid"}, m_axis_tvalid, 1'b1);
    rstn = 1'b0;
    #1;
    check1({tag, "_rst_tvalid"}, m_axis_tvalid, 1'b0);
    check({tag, "_rst_tdata"}, m_axis_tdata, 8'h00);
    check1({tag, "_rst_busy"}, busy, 1'b0);
    exp_q.delete();
    step();
    step();
    rstn = 1'b1;
    repeat (3) step();
    m_axis_tready = 1'b1;
    repeat (4) step();
    check1({tag, "_after_tvalid"}, m_axis_tvalid, 1'b0);
    check1({tag, "_after_busy"}, busy, 1'b0);
  endtask

  initial begin
    // Reset state
    m_axis_tready = 1'b1;
    #23;
    check1("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tdata", m_axis_tdata, 8'h00);
    check1("rst_overflow", key_overflow, 1'b0);
    check1("rst_busy", busy, 1'b0);
    step();
    rstn = 1'b1;
    step();

    // Single key: latency and single byte
    exp_q.push_back(8'h41);
    key(8'h41);
    check1("lat_edgeN_tvalid", m_axis_tvalid, 1'b0);
    check1("lat_edgeN_busy", busy, 1'b1);
    step();
    check1("lat_edgeN1_tvalid", m_axis_tvalid, 1'b1);
    check("lat_edgeN1_tdata", m_axis_tdata, 8'h41);
    step();
    check1("single_done_tvalid", m_axis_tvalid, 1'b0);
    check1("single_done_busy", busy, 1'b0);
    drain("single");

    // Cursor up with a stalled sink, then no bubble before the suffix
    m_axis_tready = 1'b0;
    exp_q.push_back(8'h1B);
    exp_q.push_back(8'h41);
    key(8'h80);
    step();
    check1("up_esc_valid", m_axis_tvalid, 1'b1);
    check("up_esc_data", m_axis_tdata, 8'h1B);
    repeat (4) step();
    m_axis_tready = 1'b1;
    step();
    check1("up_suffix_valid", m_axis_tvalid, 1'b1);
    check("up_suffix_data", m_axis_tdata, 8'h41);
    drain("cursor_up");

    // Identify during an in-flight ESC C
    m_axis_tready = 1'b0;
    exp_q.push_back(8'h1B);
    exp_q.push_back(8'h43);
    key(8'h82);
    step();
    exp_q.push_back(8'h1B);
    exp_q.push_back(8'h2F);
    exp_q.push_back(8'h4B);
    ident_req = 1'b1;
    step();
    ident_req = 1'b0;
    step();
    m_axis_tready = 1'b1;
    drain("ident_inflight");

    // Second identify after the first has entered its sequence: two responses
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(8'h1B);
      exp_q.push_back(8'h2F);
      exp_q.push_back(8'h4B);
    end
    ident_req = 1'b1;
    step();
    ident_req = 1'b0;
    step();
    ident_req = 1'b1;
    step();
    ident_req = 1'b0;
    drain("ident_twice");

    // Overflow: one popped and held, four buffered, sixth dropped
    m_axis_tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) exp_q.push_back(8'h61 + 8'(i));
      key(8'h61 + 8'(i));
    end
    check1("ovf_flag", key_overflow, 1'b1);
    check1("ovf_held_valid", m_axis_tvalid, 1'b1);
    check("ovf_held_data", m_axis_tdata, 8'h61);
    m_axis_tready = 1'b1;
    drain("overflow");
    check1("ovf_sticky", key_overflow, 1'b1);

    // Discarded code between two characters
    exp_q.push_back(8'h31);
    exp_q.push_back(8'h32);
    key(8'h31);
    key(8'hF0);
    key(8'h32);
    drain("discard");

    // Carriage return
    exp_q.push_back(8'h0D);
`ifdef VT52_KEY_CRLF_EN
    exp_q.push_back(8'h0A);
`endif
    key(8'h0D);
    drain("cr");

    // Reset between the two bytes of a sequence
    reset_mid("rst_mid_up", 8'h80, 8'h1B, 8'h41);
`ifdef VT52_KEY_CRLF_EN
    reset_mid("rst_mid_crlf", 8'h0D, 8'h0D, 8'h0A);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
